// File: rtl/dsm_pkg.sv
// ---------------------------------------------------------------------------
// dsm_pkg
//   Shared definitions for the delta-sigma sample sequencer:
//     VIN_FS / VIN_FS_NEG : +1.0 V / -1.0 V full-scale codes (0x0_8000 / 0xF_8000
//                           in a 20-bit word), held as 32-bit signed values so
//                           they work for any sample width up to 32 bits.
//     state_t             : sequencer FSM encoding.
//     sat_fs()            : clamps a sign-extended sample into full scale.
// ---------------------------------------------------------------------------
package dsm_pkg;

   localparam logic signed [31:0] VIN_FS     = 32'sh0000_8000;
   localparam logic signed [31:0] VIN_FS_NEG = -32'sh0000_8000;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRIME    = 3'd1,
      RUN      = 3'd2,
      UNDERRUN = 3'd3,
      RAMP     = 3'd4
   } state_t;

   function automatic logic signed [31:0] sat_fs(input logic signed [31:0] x);
      if (x > VIN_FS)
         return VIN_FS;
      else if (x < VIN_FS_NEG)
         return VIN_FS_NEG;
      else
         return x;
   endfunction

endpackage

// File: rtl/dsm_sample_fifo.sv
// ---------------------------------------------------------------------------
// dsm_sample_fifo
//   Small synchronous sample FIFO.
//   Ports:
//     clock, reset    : clock, synchronous active-high reset
//     push, push_data : write request / data (ignored when full or flushing)
//     pop             : read request (ignored when empty or flushing)
//     flush           : empties the FIFO on the next edge
//     head            : oldest entry, valid whenever !empty
//     level           : occupancy 0..DEPTH
//     full, empty     : occupancy flags from the registered level
// ---------------------------------------------------------------------------
module dsm_sample_fifo #(
   parameter int DATA_W = 20,
   parameter int DEPTH  = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [DATA_W-1:0]          head,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [LVL_W-1:0]  level_reg;
   logic              push_ok;
   logic              pop_ok;

   assign full  = (level_reg == LVL_W'(DEPTH));
   assign empty = (level_reg == '0);

   // Full blocks a push even when a pop happens in the same cycle.
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;

   always_ff @(posedge clock) begin
      if (push_ok)
         mem[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         level_reg <= level_reg + LVL_W'(push_ok) - LVL_W'(pop_ok);
      end
   end

   // Combinational head so a pop and its use on vin land on the same edge;
   // with only a handful of entries this maps to distributed RAM.
   assign head  = mem[rd_ptr_reg];
   assign level = level_reg;

endmodule

// File: rtl/dsm_sample_sequencer.sv
// ---------------------------------------------------------------------------
// dsm_sample_sequencer
//   Feeds the delta-sigma modulator: buffers PCM samples, holds each one on
//   vin for OSR modulator updates, and generates the modulator update strobe
//   and reset. Handles start-up priming, underrun and stop sequencing.
//   Ports:
//     clock, reset   : clock, synchronous active-high reset
//     enable         : 1 = run modulator, 0 = stop at the end of the period
//     s_valid/s_ready/s_data : sample input stream (saturated to full scale)
//     vin            : registered modulator input
//     dsm_en         : modulator update strobe
//     dsm_reset      : modulator state reset, active-high
//     sample_strobe  : 1-cycle pulse when vin takes a newly popped sample
//     underrun_cnt   : saturating count of periods with no sample
//     fifo_level     : sample FIFO occupancy
//   Build option DSM_SOFTSTOP_EN: when defined, stopping ramps vin to zero by
//   RAMP_STEP per update before returning to IDLE; otherwise stop is immediate.
// ---------------------------------------------------------------------------
module dsm_sample_sequencer
   import dsm_pkg::*;
#(
   parameter int DATA_W     = 20,
   parameter int OSR        = 64,
   parameter int TICK_DIV   = 1,
   parameter int FIFO_DEPTH = 4
`ifdef DSM_SOFTSTOP_EN
   ,
   parameter logic [DATA_W-1:0] RAMP_STEP = DATA_W'('h100)
`endif
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [DATA_W-1:0]              s_data,
   output logic [DATA_W-1:0]              vin,
   output logic                           dsm_en,
   output logic                           dsm_reset,
   output logic                           sample_strobe,
   output logic [15:0]                    underrun_cnt,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PH_W  = $clog2(OSR);

   state_t             state_reg;
   logic [DIV_W-1:0]   div_reg;
   logic [PH_W-1:0]    phase_reg;
   logic [DATA_W-1:0]  vin_reg;
   logic               dsm_reset_reg;
   logic               sample_strobe_reg;
   logic [15:0]        underrun_cnt_reg;

   logic               ticking;
   logic               boundary;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_flush;
   logic               fifo_full;
   logic               fifo_empty;
   logic [DATA_W-1:0]  fifo_head;
   logic [DATA_W-1:0]  push_data;
   logic [LVL_W-1:0]   level_w;

`ifdef DSM_SOFTSTOP_EN
   // Step vin toward zero, clamping so it never crosses zero.
   function automatic logic [DATA_W-1:0] ramp_toward_zero(input logic [DATA_W-1:0] v);
      logic signed [DATA_W-1:0] v_s;
      logic signed [DATA_W-1:0] step_s;
      v_s    = $signed(v);
      step_s = $signed(RAMP_STEP);
      if (v_s > step_s)
         return v - RAMP_STEP;
      else if (v_s < -step_s)
         return v + RAMP_STEP;
      else
         return '0;
   endfunction
`endif

   // Saturate the incoming sample before it is stored.
   assign push_data = DATA_W'(sat_fs(32'($signed(s_data))));

   assign s_ready   = !fifo_full && (state_reg != IDLE) && (state_reg != RAMP);
   assign fifo_push = s_valid && s_ready;

   assign ticking  = (state_reg == RUN) || (state_reg == UNDERRUN) || (state_reg == RAMP);
   assign dsm_en   = ticking && (div_reg == DIV_W'(TICK_DIV - 1));
   assign boundary = dsm_en && (phase_reg == PH_W'(OSR - 1));

   // FIFO pop/flush decisions, shared with the FSM below so both agree.
   always_comb begin
      fifo_pop   = 1'b0;
      fifo_flush = 1'b0;
      case (state_reg)
         IDLE: fifo_flush = 1'b1;
         PRIME: begin
            if (!enable)
               fifo_flush = 1'b1;
            else if (level_w >= LVL_W'(FIFO_DEPTH / 2))
               fifo_pop = 1'b1;
         end
         RUN, UNDERRUN: begin
            if (boundary) begin
               if (!enable) begin
`ifndef DSM_SOFTSTOP_EN
                  fifo_flush = 1'b1;
`endif
               end else if (!fifo_empty) begin
                  fifo_pop = 1'b1;
               end
            end
         end
`ifdef DSM_SOFTSTOP_EN
         RAMP: begin
            if (dsm_en && (vin_reg == '0))
               fifo_flush = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   dsm_sample_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (push_data),
      .pop       (fifo_pop),
      .flush     (fifo_flush),
      .head      (fifo_head),
      .level     (level_w),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg         <= IDLE;
         div_reg           <= '0;
         phase_reg         <= '0;
         vin_reg           <= '0;
         dsm_reset_reg     <= 1'b1;
         sample_strobe_reg <= 1'b0;
         underrun_cnt_reg  <= '0;
      end else begin
         sample_strobe_reg <= 1'b0;

         if (ticking) begin
            div_reg <= dsm_en ? '0 : div_reg + 1'b1;
            if (dsm_en)
               phase_reg <= (phase_reg == PH_W'(OSR - 1)) ? '0 : phase_reg + 1'b1;
         end

         case (state_reg)
            IDLE: begin
               vin_reg       <= '0;
               dsm_reset_reg <= 1'b1;
               div_reg       <= '0;
               phase_reg     <= '0;
               if (enable)
                  state_reg <= PRIME;
            end

            PRIME: begin
               if (!enable) begin
                  state_reg <= IDLE;
               end else if (fifo_pop) begin
                  vin_reg           <= fifo_head;
                  sample_strobe_reg <= 1'b1;
                  div_reg           <= '0;
                  phase_reg         <= '0;
                  dsm_reset_reg     <= 1'b0;
                  state_reg         <= RUN;
               end
            end

            RUN, UNDERRUN: begin
               // Only a period boundary changes anything, so a stop request
               // never truncates the period in progress.
               if (boundary) begin
                  if (!enable) begin
`ifdef DSM_SOFTSTOP_EN
                     state_reg <= RAMP;
`else
                     state_reg     <= IDLE;
                     vin_reg       <= '0;
                     dsm_reset_reg <= 1'b1;
`endif
                  end else if (fifo_pop) begin
                     vin_reg           <= fifo_head;
                     sample_strobe_reg <= 1'b1;
                     state_reg         <= RUN;
                  end else begin
                     vin_reg <= '0;
                     if (underrun_cnt_reg != 16'hFFFF)
                        underrun_cnt_reg <= underrun_cnt_reg + 1'b1;
                     state_reg <= UNDERRUN;
                  end
               end
            end

`ifdef DSM_SOFTSTOP_EN
            RAMP: begin
               // enable is deliberately ignored until the ramp reaches IDLE.
               if (dsm_en) begin
                  if (vin_reg == '0) begin
                     state_reg     <= IDLE;
                     dsm_reset_reg <= 1'b1;
                  end else begin
                     vin_reg <= ramp_toward_zero(vin_reg);
                  end
               end
            end
`endif

            default: state_reg <= IDLE;
         endcase
      end
   end

   assign vin           = vin_reg;
   assign dsm_reset     = dsm_reset_reg;
   assign sample_strobe = sample_strobe_reg;
   assign underrun_cnt  = underrun_cnt_reg;
   assign fifo_level    = level_w;

endmodule

// File: tb/tb_dsm_sample_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dsm_sample_sequencer
//   Directed bench for dsm_sample_sequencer. Instance A uses OSR=4,
//   TICK_DIV=1; instance B uses OSR=4, TICK_DIV=3. Outputs are sampled 1 ns
//   after the rising edge; expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_dsm_sample_sequencer;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;

   logic        enable_a, s_valid_a, s_ready_a;
   logic [19:0] s_data_a, vin_a;
   logic        dsm_en_a, dsm_reset_a, sample_strobe_a;
   logic [15:0] underrun_cnt_a;
   logic [2:0]  fifo_level_a;

   logic        enable_b, s_valid_b, s_ready_b;
   logic [19:0] s_data_b, vin_b;
   logic        dsm_en_b, dsm_reset_b, sample_strobe_b;
   logic [15:0] underrun_cnt_b;
   logic [2:0]  fifo_level_b;

   int n_checks = 0;
   int n_fail   = 0;
   int en_count;

   dsm_sample_sequencer #(.DATA_W(20), .OSR(4), .TICK_DIV(1), .FIFO_DEPTH(4)) dut_a (
      .clock(clock), .reset(reset), .enable(enable_a),
      .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a),
      .vin(vin_a), .dsm_en(dsm_en_a), .dsm_reset(dsm_reset_a),
      .sample_strobe(sample_strobe_a), .underrun_cnt(underrun_cnt_a),
      .fifo_level(fifo_level_a)
   );

   dsm_sample_sequencer #(.DATA_W(20), .OSR(4), .TICK_DIV(3), .FIFO_DEPTH(4)) dut_b (
      .clock(clock), .reset(reset), .enable(enable_b),
      .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
      .vin(vin_b), .dsm_en(dsm_en_b), .dsm_reset(dsm_reset_b),
      .sample_strobe(sample_strobe_b), .underrun_cnt(underrun_cnt_b),
      .fifo_level(fifo_level_b)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      enable_a = 1'b0; s_valid_a = 1'b0; s_data_a = '0;
      enable_b = 1'b0; s_valid_b = 1'b0; s_data_b = '0;
      tick();
      tick();

      // Reset state
      check("rst_vin",        vin_a, 32'h0);
      check("rst_dsm_en",     dsm_en_a, 32'h0);
      check("rst_dsm_reset",  dsm_reset_a, 32'h1);
      check("rst_strobe",     sample_strobe_a, 32'h0);
      check("rst_underrun",   underrun_cnt_a, 32'h0);
      check("rst_level",      fifo_level_a, 32'h0);
      check("rst_s_ready",    s_ready_a, 32'h0);

      // T1: priming and first two samples
      reset = 1'b0;
      enable_a = 1'b1;
      tick();
      check("prime_s_ready",   s_ready_a, 32'h1);
      check("prime_dsm_reset", dsm_reset_a, 32'h1);
      check("prime_dsm_en",    dsm_en_a, 32'h0);
      s_valid_a = 1'b1; s_data_a = 20'h0_4000;
      tick();
      check("prime_level1", fifo_level_a, 32'h1);
      s_data_a = 20'hF_C000;
      tick();
      s_valid_a = 1'b0;
      check("prime_level2", fifo_level_a, 32'h2);
      check("prime_no_strobe", sample_strobe_a, 32'h0);
      tick();
      check("t1_vin0",       vin_a, 32'h0_4000);
      check("t1_strobe0",    sample_strobe_a, 32'h1);
      check("t1_dsm_reset",  dsm_reset_a, 32'h0);
      check("t1_level",      fifo_level_a, 32'h1);
      check("t1_dsm_en",     dsm_en_a, 32'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t1_vin_hold",   vin_a, 32'h0_4000);
         check("t1_strobe_low", sample_strobe_a, 32'h0);
      end
      tick();
      check("t1_vin1",    vin_a, 32'hF_C000);
      check("t1_strobe1", sample_strobe_a, 32'h1);
      check("t1_level0",  fifo_level_a, 32'h0);

      // T2: saturation on input
      s_valid_a = 1'b1; s_data_a = 20'h1_0000;
      tick();
      s_data_a = 20'hE_0000;
      tick();
      s_valid_a = 1'b0;
      check("t2_level", fifo_level_a, 32'h2);
      tick();
      tick();
      check("t2_sat_pos",    vin_a, 32'h0_8000);
      check("t2_strobe_pos", sample_strobe_a, 32'h1);
      repeat (4) tick();
      check("t2_sat_neg", vin_a, 32'hF_8000);
      check("t2_level0",  fifo_level_a, 32'h0);

      // T3: underrun and recovery
      repeat (4) tick();
      check("t3_vin_zero",   vin_a, 32'h0);
      check("t3_underrun1",  underrun_cnt_a, 32'h1);
      check("t3_no_strobe",  sample_strobe_a, 32'h0);
      check("t3_dsm_en",     dsm_en_a, 32'h1);
      check("t3_dsm_reset",  dsm_reset_a, 32'h0);
      s_valid_a = 1'b1; s_data_a = 20'h0_2000;
      tick();
      s_valid_a = 1'b0;
      check("t3_level1",    fifo_level_a, 32'h1);
      check("t3_vin_still0", vin_a, 32'h0);
      repeat (3) tick();
      check("t3_recover_vin",    vin_a, 32'h0_2000);
      check("t3_recover_strobe", sample_strobe_a, 32'h1);
      check("t3_underrun_keep",  underrun_cnt_a, 32'h1);

      // Stop mid-period on instance A
      tick();
      enable_a = 1'b0;
`ifndef DSM_SOFTSTOP_EN
      tick();
      check("stop_hold_vin",   vin_a, 32'h0_2000);
      check("stop_hold_reset", dsm_reset_a, 32'h0);
      tick();
      check("stop_last_en",    dsm_en_a, 32'h1);
      tick();
      check("stop_vin",        vin_a, 32'h0);
      check("stop_dsm_reset",  dsm_reset_a, 32'h1);
      check("stop_dsm_en",     dsm_en_a, 32'h0);
      check("stop_level",      fifo_level_a, 32'h0);
      check("stop_s_ready",    s_ready_a, 32'h0);
      check("stop_underrun",   underrun_cnt_a, 32'h1);
`else
      for (int i = 0; i < 64 && !dsm_reset_a; i++)
         tick();
      check("softstop_reach_idle", dsm_reset_a, 32'h1);
`endif

      // T6 prelude: fill FIFO in RUN, full blocks push, then reset
      enable_a = 1'b1;
      tick();
      s_valid_a = 1'b1; s_data_a = 20'h0_0100;
      tick();
      tick();
      tick();
      check("t6_run_strobe", sample_strobe_a, 32'h1);
      check("t6_run_vin",    vin_a, 32'h0_0100);
      check("t6_level2",     fifo_level_a, 32'h2);
      tick();
      check("t6_level3",     fifo_level_a, 32'h3);
      check("t6_dsm_reset",  dsm_reset_a, 32'h0);
      tick();
      check("full_level4",   fifo_level_a, 32'h4);
      check("full_s_ready",  s_ready_a, 32'h0);
      tick();
      check("full_blocked",  fifo_level_a, 32'h4);
      s_valid_a = 1'b0;
      enable_a = 1'b0;
      reset = 1'b1;
      tick();
      check("t6_vin",        vin_a, 32'h0);
      check("t6_dsm_en",     dsm_en_a, 32'h0);
      check("t6_dsm_reset1", dsm_reset_a, 32'h1);
      check("t6_strobe",     sample_strobe_a, 32'h0);
      check("t6_underrun",   underrun_cnt_a, 32'h0);
      check("t6_level0",     fifo_level_a, 32'h0);
      check("t6_s_ready",    s_ready_a, 32'h0);
      reset = 1'b0;

      // T4: TICK_DIV=3 on instance B, stop requested at phase 1
      enable_b = 1'b1;
      tick();
      s_valid_b = 1'b1; s_data_b = 20'h0_3000;
      tick();
      s_data_b = 20'h0_5000;
      tick();
      s_valid_b = 1'b0;
      tick();
      check("t4_vin",     vin_b, 32'h0_3000);
      check("t4_strobe",  sample_strobe_b, 32'h1);
      check("t4_en_c0",   dsm_en_b, 32'h0);
      tick();
      check("t4_en_c1",   dsm_en_b, 32'h0);
      tick();
      check("t4_en_c2",   dsm_en_b, 32'h1);
      tick();
      check("t4_en_c3",   dsm_en_b, 32'h0);
      enable_b = 1'b0;
      en_count = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (dsm_en_b)
            en_count++;
      end
      check("t4_en_count",      en_count, 32'd3);
      check("t4_last_vin",      vin_b, 32'h0_3000);
      check("t4_last_reset",    dsm_reset_b, 32'h0);
      tick();
      check("t4_idle_vin",      vin_b, 32'h0);
      check("t4_idle_reset",    dsm_reset_b, 32'h1);
      check("t4_idle_level",    fifo_level_b, 32'h0);
      check("t4_idle_dsm_en",   dsm_en_b, 32'h0);

`ifdef DSM_SOFTSTOP_EN
      // T5: soft-stop ramp on instance A
      enable_a = 1'b1;
      tick();
      s_valid_a = 1'b1; s_data_a = 20'h0_0250;
      tick();
      tick();
      s_valid_a = 1'b0;
      tick();
      check("t5_run_vin", vin_a, 32'h0_0250);
      enable_a = 1'b0;
      repeat (3) tick();
      tick();
      check("t5_ramp_entry_vin", vin_a, 32'h0_0250);
      check("t5_ramp_s_ready",   s_ready_a, 32'h0);
      tick();
      check("t5_ramp1", vin_a, 32'h0_0150);
      tick();
      check("t5_ramp2", vin_a, 32'h0_0050);
      tick();
      check("t5_ramp3", vin_a, 32'h0);
      check("t5_ramp3_reset", dsm_reset_a, 32'h0);
      tick();
      check("t5_idle_reset", dsm_reset_a, 32'h1);
      check("t5_idle_level", fifo_level_a, 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
